// File: rtl/alu_exec_unit_pkg.sv
`default_nettype none
// ============================================================================
// alu_exec_unit_pkg : ALU control codes and output-buffer state encoding
// Revision: 1.0
// ============================================================================
package alu_exec_unit_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam int DEFAULT_WIDTH = 32;

  // Buffer state is its occupancy.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// alu_core : combinational ALU (add/sub/and/or/slt) with zero and illegal flags
// Revision: 1.0
// ============================================================================
module alu_core
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  logic w_lt;

  assign w_lt = $signed(src_a) < $signed(src_b);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (alu_control)
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, w_lt};
      default: illegal = 1'b1;
    endcase
    // Illegal codes leave result at 0, so zero is set for them as well.
    zero = (result == '0);
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// alu_exec_unit : registered execute stage with a 2-entry result buffer
// Revision: 1.0
// ============================================================================
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [CNT_W-1:0] op_count
);

  buf_state_t r_state;
  buf_state_t w_state_next;

  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_zero;
  logic             w_alu_illegal;

  logic [WIDTH-1:0] r_head_result;
  logic             r_head_zero;
  logic             r_head_illegal;
  logic [WIDTH-1:0] r_tail_result;
  logic             r_tail_zero;
  logic             r_tail_illegal;
  logic [CNT_W-1:0] r_op_count;

  logic w_push;
  logic w_pop;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .result      (w_alu_result),
    .zero        (w_alu_zero),
    .illegal     (w_alu_illegal)
  );

  // rst gates in_ready only so upstream sees not-ready while reset is held.
  assign in_ready  = rst && (r_state != BUF_TWO);
  assign out_valid = (r_state != BUF_EMPTY);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BUF_EMPTY: if (w_push) w_state_next = BUF_ONE;
      BUF_ONE: begin
        if (w_push && !w_pop)      w_state_next = BUF_TWO;
        else if (!w_push && w_pop) w_state_next = BUF_EMPTY;
      end
      BUF_TWO: if (w_pop) w_state_next = BUF_ONE;
      default: w_state_next = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= BUF_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head_result  <= '0;
      r_head_zero    <= 1'b0;
      r_head_illegal <= 1'b0;
      r_tail_result  <= '0;
      r_tail_zero    <= 1'b0;
      r_tail_illegal <= 1'b0;
      r_op_count     <= '0;
    end else begin
      case (r_state)
        BUF_EMPTY: begin
          if (w_push) begin
            r_head_result  <= w_alu_result;
            r_head_zero    <= w_alu_zero;
            r_head_illegal <= w_alu_illegal;
          end
        end
        BUF_ONE: begin
          // On push+pop the new entry replaces the departing head directly.
          if (w_push && w_pop) begin
            r_head_result  <= w_alu_result;
            r_head_zero    <= w_alu_zero;
            r_head_illegal <= w_alu_illegal;
          end else if (w_push) begin
            r_tail_result  <= w_alu_result;
            r_tail_zero    <= w_alu_zero;
            r_tail_illegal <= w_alu_illegal;
          end
        end
        BUF_TWO: begin
          if (w_pop) begin
            r_head_result  <= r_tail_result;
            r_head_zero    <= r_tail_zero;
            r_head_illegal <= r_tail_illegal;
          end
        end
        default: ;
      endcase
      if (w_pop) begin
        r_op_count <= r_op_count + CNT_W'(1);
      end
    end
  end

  assign result   = r_head_result;
  assign zero     = r_head_zero;
  assign illegal  = r_head_illegal;
  assign op_count = r_op_count;

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the 3-bit ALU control code produced by the ALU decoder.
- Accepts an operation with its two operands over a valid/ready handshake, computes the result and flags, and holds results in a 2-entry output buffer until downstream accepts them.
- Serves as the registered execute stage for the pipelined/multi-cycle core variants, decoupling decode from writeback stalls.

Parameters:
- WIDTH, 32, operand/result width in bits (must be >= 2).
- CNT_W, 16, width of the retired-operation counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept an operation this cycle.
- alu_control  input  3  operation code: 000 add, 001 sub, 010 and, 011 or, 101 slt; 100/110/111 illegal.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B.
- out_valid  output  1  buffer head holds a result.
- out_ready  input  1  downstream accepts head this cycle.
- result  output  WIDTH  head result.
- zero  output  1  head result == 0.
- illegal  output  1  head came from an illegal code.
- op_count  output  CNT_W  number of results popped since reset.

Behaviour:
- Reset (rst low, asynchronous): buffer emptied; out_valid=0, result=0, zero=0, illegal=0, op_count=0; in_ready=0 while rst is low.
- Reset mid-operation: in-flight and buffered results are discarded, with no partial pop and no count increment.
- Accept: push when in_valid && in_ready on a rising edge. The result is computed combinationally from the inputs sampled that edge and written into the buffer.
- Latency: result visible at the head with out_valid=1 one cycle after accept when the buffer was empty. Otherwise it is visible behind existing entries, in FIFO order.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH, with no carry/overflow output.
  - and/or are bitwise.
  - slt: result = 1 if $signed(src_a) < $signed(src_b), else 0, zero-extended to WIDTH.
- Illegal code: result=0, zero=1, illegal=1. It is still buffered and handshaked like a normal op.
- zero and illegal travel with their entry in the buffer and are not recomputed at the head.
- Pop: when out_valid && out_ready, the head is removed and op_count increments, wrapping from 2^CNT_W-1 to 0.
- Buffer FSM (state = occupancy):
  - EMPTY:
    - push -> ONE.
    - no push -> EMPTY.
    - out_valid=0; in_ready=1.
  - ONE:
    - push && pop -> ONE (the new entry becomes head).
    - push only -> TWO.
    - pop only -> EMPTY.
    - neither -> ONE.
    - in_ready=1.
  - TWO:
    - pop -> ONE (second entry becomes head).
    - otherwise -> TWO.
    - in_ready=0, so push is impossible.
- Timing paths:
  - in_ready is a function of state only; there is no combinational path from out_ready to in_ready.
  - The output fields are driven from registers only.
- Full boundary: in TWO, in_valid is ignored and the inputs are not sampled. Upstream must hold its operation until in_ready=1.
- Empty boundary: out_ready with out_valid=0 has no effect; op_count is unchanged.
- While out_valid=1 and out_ready=0, result/zero/illegal are held stable.
- Output fields are don't-care while out_valid=0, but must read 0 after reset.

Decomposition:
- Shared package: ALU code constants (ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101), default WIDTH, and the buffer state encoding (EMPTY/ONE/TWO).
- The decoder and this unit both use these constants.
- One sub-module, alu_core: purely combinational (alu_control, src_a, src_b) -> (result, zero, illegal). It is reusable by the single-cycle datapath.
- alu_exec_unit holds the FSM, the 2-entry buffer and op_count.

Test Plan:
- Reset then single add: apply rst low then high; push add, src_a=5, src_b=7, with out_ready=1 -> next cycle out_valid=1, result=12, zero=0, illegal=0; op_count=1 after the pop.
- Sub and slt boundaries:
  - sub 3-3 -> result=0, zero=1.
  - sub 0-1 -> result=32'hFFFFFFFF.
  - slt 32'hFFFFFFFF vs 1 -> result=1.
  - slt 1 vs 32'hFFFFFFFF -> result=0.
- Backpressure/full: with out_ready=0, push and 0xF0|0x3C, then or 0xF0|0x0F; in_ready=0 in TWO and a third push is held. Then out_ready=1 -> results 0x30, 0xFF in order, followed by the held op.
- Simultaneous push+pop in ONE: stream 10 back-to-back adds with out_ready=1 -> in_ready stays 1, one result per cycle, in order, op_count=10.
- Illegal code: push alu_control=3'b110, src_a=9, src_b=9 -> result=0, zero=1, illegal=1; the next legal op has illegal=0.
- Async reset mid-operation: fill to TWO, then drop rst between clock edges -> out_valid=0, in_ready=0 and op_count=0 immediately. After release the buffer is empty and the popped entries never appear.
